// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage types: ALUOp encodings, ALU control, branch funct3 codes, opcodes.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OPCODE_R = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_t;

  // funct7[5] only selects SUB for register-register ops; addi ignores it.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] aluop, input logic [2:0] funct3,
                                           input logic funct7b5, input logic [6:0] opcode);
    alu_decode = ALU_ADD;
    case (aluop)
      ALUOP_ADD:    alu_decode = ALU_ADD;
      ALUOP_BRANCH: alu_decode = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_decode = (funct7b5 && opcode == OPCODE_R) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_decode = ALU_SLL;
          3'b010:  alu_decode = ALU_SLT;
          3'b011:  alu_decode = ALU_SLTU;
          3'b100:  alu_decode = ALU_XOR;
          3'b101:  alu_decode = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_decode = ALU_OR;
          default: alu_decode = ALU_AND;
        endcase
      end
      default:      alu_decode = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I ALU; the comparison flags always describe a versus b regardless of ctrl.
module exec_alu
  import riscv_pkg::*;
(
  input  alu_ctrl_t         ctrl,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              lt,
  output logic              ltu
);
  logic [$clog2(XLEN)-1:0] shamt;

  assign shamt = b[$clog2(XLEN)-1:0];
  assign zero  = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU control, branch resolution and the EX/MEM pipeline register.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              BranchE,
  input  logic              MemReadE,
  input  logic              MemWriteE,
  input  logic              memtoRegE,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ALUOpE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   ReadData1E,
  input  logic [XLEN-1:0]   ReadData2E,
  input  logic [XLEN-1:0]   immediateE,
  input  logic [XLEN-1:0]   InstrE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   WriteDataW,
  input  logic              StallM,
  output logic              RegWriteM,
  output logic              MemReadM,
  output logic              MemWriteM,
  output logic              memtoRegM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [REG_AW-1:0] RdM,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE
);
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   fwd_a, fwd_b, src_b, alu_result;
  logic              zero, lt, ltu, taken;
  alu_ctrl_t         alu_ctrl;
  logic [5:0]        unused_instr;

  assign rs1          = InstrE[19:15];
  assign rs2          = InstrE[24:20];
  assign rd           = InstrE[11:7];
  assign funct3       = InstrE[14:12];
  assign unused_instr = {InstrE[31], InstrE[29:25]};

  // M beats W so the youngest producer wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = ReadData1E;
    if (RegWriteM && RdM != '0 && RdM == rs1)      fwd_a = ALUResultM;
    else if (RegWriteW && RdW != '0 && RdW == rs1) fwd_a = WriteDataW;
  end

  always_comb begin
    fwd_b = ReadData2E;
    if (RegWriteM && RdM != '0 && RdM == rs2)      fwd_b = ALUResultM;
    else if (RegWriteW && RdW != '0 && RdW == rs2) fwd_b = WriteDataW;
  end

  assign src_b    = ALUSrcE ? immediateE : fwd_b;
  assign alu_ctrl = alu_decode(ALUOpE, funct3, InstrE[30], InstrE[6:0]);

  exec_alu u_alu (
    .ctrl   (alu_ctrl),
    .a      (fwd_a),
    .b      (src_b),
    .result (alu_result),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu)
  );

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE    = BranchE && taken;
  assign PCTargetE = PCE + immediateE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      memtoRegM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemReadM   <= MemReadE;
      MemWriteM  <= MemWriteE;
      memtoRegM  <= memtoRegE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      RdM        <= rd;
    end
  end
endmodule

// File: tb/tb_execute_cycle.sv
// Table-driven bench for execute_cycle with a scoreboard queue for EX/MEM results.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        BranchE, MemReadE, MemWriteE, memtoRegE, RegWriteE, ALUSrcE;
  logic [1:0]  ALUOpE;
  logic [31:0] PCE, ReadData1E, ReadData2E, immediateE, InstrE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] WriteDataW;
  logic        StallM;
  logic        RegWriteM, MemReadM, MemWriteM, memtoRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst), .BranchE(BranchE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .memtoRegE(memtoRegE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE),
    .PCE(PCE), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .immediateE(immediateE),
    .InstrE(InstrE), .RegWriteW(RegWriteW), .RdW(RdW), .WriteDataW(WriteDataW),
    .StallM(StallM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .memtoRegM(memtoRegM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
  );

  // control bundle {branch, memread, memwrite, memtoreg, regwrite}
  localparam logic [4:0] C_NONE = 5'b00000, C_R = 5'b00001, C_B = 5'b10000;
  localparam logic [4:0] C_ST = 5'b00100, C_LD = 5'b01011;

  typedef struct {
    logic [1:0]  aluop;
    logic        alusrc;
    logic [4:0]  c;
    logic [31:0] instr, rd1, rd2, imm, pc;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic [31:0] res, wd;
    logic        pcs;
    logic [31:0] tgt;
  } vec_t;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] res, wd;
    logic [4:0]  rd;
  } m_t;

  int   n_vec = 0;
  int   n_err = 0;
  m_t   sb[$];
  vec_t tv[24];

  function automatic vec_t mk(input logic [1:0] aluop, input logic alusrc, input logic [4:0] c,
                              input logic [31:0] instr, rd1, rd2, imm, pc,
                              input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                              input logic [31:0] res, wd, input logic pcs, input logic [31:0] tgt);
    vec_t v;
    v.aluop = aluop; v.alusrc = alusrc; v.c = c; v.instr = instr; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.pc = pc; v.wbe = wbe; v.wbr = wbr; v.wbd = wbd; v.res = res; v.wd = wd;
    v.pcs = pcs; v.tgt = tgt;
    return v;
  endfunction

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] b_ins(input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {7'h00, rs2, rs1, f3, 5'h00, 7'h63};
  endfunction

  function automatic m_t expect_of(input vec_t v);
    m_t m;
    m.ctl = {v.c[0], v.c[3], v.c[2], v.c[1]};
    m.res = v.res;
    m.wd  = v.wd;
    m.rd  = v.instr[11:7];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {BranchE, MemReadE, MemWriteE, memtoRegE, RegWriteE} = v.c;
    ALUOpE = v.aluop; ALUSrcE = v.alusrc; InstrE = v.instr;
    ReadData1E = v.rd1; ReadData2E = v.rd2; immediateE = v.imm; PCE = v.pc;
    RegWriteW = v.wbe; RdW = v.wbr; WriteDataW = v.wbd;
  endtask

  task automatic check_m(input string tag, input m_t e);
    chk({tag, "_ctl"}, {28'd0, RegWriteM, MemReadM, MemWriteM, memtoRegM}, {28'd0, e.ctl});
    chk({tag, "_res"}, ALUResultM, e.res);
    chk({tag, "_wd"}, WriteDataM, e.wd);
    chk({tag, "_rd"}, {27'd0, RdM}, {27'd0, e.rd});
  endtask

  task automatic check_zero(input string tag);
    m_t z;
    z.ctl = 4'd0; z.res = 32'd0; z.wd = 32'd0; z.rd = 5'd0;
    check_m(tag, z);
  endtask

  task automatic pop_check(input string tag);
    m_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty got %h expected entry", tag, ALUResultM);
    end else begin
      e = sb.pop_front();
      check_m(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    m_t   held;

    tv[0]  = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'd12, 32'd7, 0, 32'd0);
    tv[1]  = mk(2'b10, 0, C_R, r_ins(7'h20, 5'd3, 5'd3, 3'd0, 5'd4), 32'h55, 32'h55, 32'd0, 32'd0,
                1, 5'd3, 32'd99, 32'd0, 32'd12, 0, 32'd0);
    tv[2]  = mk(2'b00, 1, C_R, {12'h010, 5'd1, 3'd0, 5'd0, 7'h13}, 32'h1234, 32'd0, 32'h10, 32'd0,
                1, 5'd0, 32'd77, 32'h1244, 32'd0, 0, 32'h10);
    tv[3]  = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 32'd0, 32'd0, 32'd0, 32'd0,
                1, 5'd0, 32'hDEAD, 32'd0, 32'd0, 0, 32'd0);
    tv[4]  = mk(2'b10, 0, C_R, r_ins(7'h20, 5'd10, 5'd9, 3'd0, 5'd8), 32'd1, 32'd30, 32'd0, 32'd0,
                1, 5'd9, 32'd100, 32'd70, 32'd30, 0, 32'd0);
    tv[5]  = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd20, 3'd4), 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h100,
                0, 5'd0, 32'd0, 32'hFFFFFFFE, 32'd1, 1, 32'hF8);
    tv[6]  = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd20, 3'd6), 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h100,
                0, 5'd0, 32'd0, 32'hFFFFFFFE, 32'd1, 0, 32'hF8);
    tv[7]  = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd20, 3'd0), 32'h42, 32'h42, 32'h20, 32'hFFFFFFF0,
                0, 5'd0, 32'd0, 32'd0, 32'h42, 1, 32'h10);
    tv[8]  = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd20, 3'd5), 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd4, 32'd0,
                0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFB, 1, 32'd4);
    tv[9]  = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd20, 3'd2), 32'd0, 32'd0, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
    tv[10] = mk(2'b01, 0, C_NONE, b_ins(5'd21, 5'd20, 3'd1), 32'd1, 32'd2, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'hFFFFFFFF, 32'd2, 0, 32'd0);
    tv[11] = mk(2'b10, 0, C_R, r_ins(7'h20, 5'd21, 5'd20, 3'd5, 5'd13), 32'h80000000, 32'd4, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'hF8000000, 32'd4, 0, 32'd0);
    tv[12] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd5, 5'd14), 32'h80000000, 32'd4, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'h08000000, 32'd4, 0, 32'd0);
    tv[13] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd3, 5'd15), 32'd0, 32'hFFFFFFFF, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 32'd0);
    tv[14] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd2, 5'd16), 32'hFFFFFFFF, 32'd1, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'd1, 32'd1, 0, 32'd0);
    tv[15] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd1, 5'd17), 32'd1, 32'h25, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'h20, 32'h25, 0, 32'd0);
    tv[16] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd4, 5'd18), 32'hF0F0, 32'h0FF0, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'hFF00, 32'h0FF0, 0, 32'd0);
    tv[17] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd6, 5'd19), 32'hF0F0, 32'h0FF0, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'hFFF0, 32'h0FF0, 0, 32'd0);
    tv[18] = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd7, 5'd22), 32'hF0F0, 32'h0FF0, 32'd0,
                32'd0, 0, 5'd0, 32'd0, 32'h00F0, 32'h0FF0, 0, 32'd0);
    tv[19] = mk(2'b10, 1, C_R, {12'h400, 5'd20, 3'd0, 5'd23, 7'h13}, 32'd10, 32'd0, 32'd5, 32'd0,
                0, 5'd0, 32'd0, 32'd15, 32'd0, 0, 32'd5);
    tv[20] = mk(2'b11, 0, C_R, r_ins(7'h20, 5'd21, 5'd20, 3'd0, 5'd24), 32'd3, 32'd4, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'd7, 32'd4, 0, 32'd0);
    tv[21] = mk(2'b00, 1, C_ST, {7'h00, 5'd21, 5'd20, 3'd2, 5'd0, 7'h23}, 32'h1000, 32'hCAFE, 32'd8,
                32'd0, 0, 5'd0, 32'd0, 32'h1008, 32'hCAFE, 0, 32'd8);
    tv[22] = mk(2'b00, 1, C_LD, {12'h008, 5'd20, 3'd2, 5'd25, 7'h03}, 32'h1000, 32'd0, 32'd8, 32'd0,
                0, 5'd0, 32'd0, 32'h1008, 32'd0, 0, 32'd8);
    tv[23] = mk(2'b00, 0, C_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);

    // Reset with nonzero inputs: or x5,x6,x7
    rst = 1'b0; StallM = 1'b0;
    v = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd7, 5'd6, 3'd6, 5'd5), 32'hF0, 32'h0F, 32'd0, 32'd0,
           0, 5'd0, 32'd0, 32'hFF, 32'h0F, 0, 32'd0);
    drive(v);
    #1 check_zero("reset_hold0");
    @(posedge clk); @(posedge clk); #1 check_zero("reset_hold");
    @(negedge clk); rst = 1'b1;
    sb.push_back(expect_of(v));
    @(posedge clk); #1 pop_check("reset_release");

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, tv[i].pcs});
      chk($sformatf("v%0d_target", i), PCTargetE, tv[i].tgt);
      sb.push_back(expect_of(tv[i]));
      @(posedge clk); #1 pop_check($sformatf("v%0d", i));
    end

    // Stall: capture add x2 then hold for three cycles while inputs change.
    @(negedge clk);
    v = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd0, 5'd2), 32'd1, 32'd1, 32'd0, 32'd0,
           0, 5'd0, 32'd0, 32'd2, 32'd1, 0, 32'd0);
    drive(v);
    held = expect_of(v);
    sb.push_back(held);
    @(posedge clk); #1 pop_check("stall_pre");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      StallM = 1'b1;
      case (i)
        0: v = mk(2'b00, 1, C_ST, r_ins(7'h00, 5'd21, 5'd20, 3'd0, 5'd9), 32'd100, 32'd200, 32'd4,
                  32'd0, 1, 5'd21, 32'd55, 32'd0, 32'd0, 0, 32'd0);
        1: v = mk(2'b01, 0, C_B, b_ins(5'd21, 5'd2, 3'd0), 32'd7, 32'd2, 32'd0, 32'd0,
                  0, 5'd0, 32'd0, 32'd0, 32'd0, 1, 32'd0);
        default: v = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd2, 3'd0, 5'd5), 32'd7, 32'd10, 32'd0,
                        32'd0, 0, 5'd0, 32'd0, 32'd12, 32'd10, 0, 32'd0);
      endcase
      drive(v);
      #1;
      if (i == 1) chk("stall_fwd_beq", {31'd0, PCSrcE}, 32'd1);
      @(posedge clk); #1 check_m($sformatf("stall%0d", i), held);
    end
    @(negedge clk);
    StallM = 1'b0;
    sb.push_back(expect_of(v));
    @(posedge clk); #1 pop_check("stall_release");

    // Asynchronous reset mid-cycle while stalled.
    @(negedge clk);
    StallM = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst = 1'b1; StallM = 1'b0;
    v = mk(2'b10, 0, C_R, r_ins(7'h00, 5'd21, 5'd20, 3'd0, 5'd6), 32'd3, 32'd4, 32'd0, 32'd0,
           0, 5'd0, 32'd0, 32'd7, 32'd4, 0, 32'd0);
    drive(v);
    sb.push_back(expect_of(v));
    @(posedge clk); #1 pop_check("post_midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
